// File: rtl/xor_stream_checksum.sv
// xor_stream_checksum: folds a framed stream of words into an XOR/XNOR checksum behind valid/ready handshakes
module xor_stream_checksum #(
    parameter int WIDTH   = 4,
    parameter int COUNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COUNT_W-1:0] len,
    input  logic               invert,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic [COUNT_W-1:0] ONE = 1;

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               inv_q, inv_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               beat, last;

    assign beat = in_valid && (state_q == ACCUM);
    assign last = cnt_q == ONE;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        inv_d   = inv_q;
        out_d   = out_q;
        if (state_q == IDLE && start && len != '0) begin
            acc_d   = '0;
            cnt_d   = len;
            inv_d   = invert;
            state_d = ACCUM;
        end else if (state_q == IDLE && start) begin
            out_d   = {WIDTH{invert}};
            state_d = DONE;
        end else if (beat) begin
            // the counter parks at 1 on the final beat instead of reaching 0
            acc_d   = acc_q ^ in_data;
            cnt_d   = last ? cnt_q : cnt_q - ONE;
            out_d   = last ? (acc_q ^ in_data) ^ {WIDTH{inv_q}} : out_q;
            state_d = last ? DONE : ACCUM;
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            inv_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            inv_q   <= inv_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = state_q == ACCUM;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign out_data  = out_q;
endmodule

// File: tb/tb_xor_stream_checksum.sv
// tb_xor_stream_checksum: directed frames checked against a frame-level checksum model every cycle
module tb_xor_stream_checksum;
    localparam int W = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] len = '0;
    logic          invert = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          busy;

    int n_cmp = 0;
    int n_fail = 0;

    xor_stream_checksum #(.WIDTH(W), .COUNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .invert(invert),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a frame is open from start until its checksum is taken;
    // it wants words until it holds len of them, then offers their folded value.
    logic         m_active = 1'b0;
    int           m_len = 0;
    logic         m_inv = 1'b0;
    logic [W-1:0] m_words[$];
    logic [W-1:0] m_sum = '0;
    logic         started = 1'b0;

    function automatic logic [W-1:0] fold(input logic [W-1:0] q[$], input logic inv);
        logic [W-1:0] r = '0;
        foreach (q[i]) r = r ^ q[i];
        return inv ? ~r : r;
    endfunction

    always @(posedge clk) begin
        started = 1'b1;
        if (rst) begin
            m_active = 1'b0;
            m_words.delete();
            m_sum = '0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1;
                m_len = int'(len);
                m_inv = invert;
                m_words.delete();
                if (len == '0) m_sum = invert ? '1 : '0;
            end
        end else if (m_words.size() < m_len) begin
            if (in_valid) begin
                m_words.push_back(in_data);
                if (m_words.size() == m_len) m_sum = fold(m_words, m_inv);
            end
        end else if (out_ready) begin
            m_active = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", in_ready, m_active && m_words.size() < m_len);
            chk("out_valid", out_valid, m_active && m_words.size() == m_len);
            chk("busy", busy, m_active);
            chk("out_data", out_data, m_sum);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int l, input logic inv);
        start = 1'b1;
        len = CW'(l);
        invert = inv;
        cyc();
        start = 1'b0;
        len = '0;
        invert = 1'b0;
    endtask

    task automatic beat(input logic [W-1:0] d, input int gap);
        in_valid = 1'b0;
        repeat (gap) cyc();
        in_valid = 1'b1;
        in_data = d;
        cyc();
        in_valid = 1'b0;
    endtask

    // Holds out_ready low for 'hold' cycles, then takes the checksum within a bounded wait.
    task automatic take(input string name, input logic [W-1:0] exp, input int hold, input logic poke_start);
        int k = 0;
        out_ready = 1'b0;
        start = poke_start;
        repeat (hold) begin
            chk({name, "_held_valid"}, out_valid, 1'b1);
            chk({name, "_held_data"}, out_data, exp);
            cyc();
        end
        out_ready = 1'b1;
        while (!out_valid && k < 20) begin
            cyc();
            k++;
        end
        chk({name, "_valid"}, out_valid, 1'b1);
        chk({name, "_data"}, out_data, exp);
        cyc();
        out_ready = 1'b0;
        start = 1'b0;
        chk({name, "_idle_after"}, busy, 1'b0);
        chk({name, "_valid_drop"}, out_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset with random inputs
        rst = 1'b1;
        {start, invert, in_valid, out_ready} = 4'($urandom);
        len = CW'($urandom);
        in_data = W'($urandom);
        cyc();
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_data", out_data, 4'b0000);
        {start, invert, in_valid, out_ready} = 4'($urandom);
        cyc();
        rst = 1'b0;
        {start, invert, in_valid, out_ready} = 4'b0;
        cyc();

        // two back-to-back beats, consumer ready
        start_frame(2, 1'b0);
        beat(4'b0101, 0);
        beat(4'b0010, 0);
        take("t2", 4'b0111, 0, 1'b0);

        // gapped beats, consumer stalls three cycles
        start_frame(3, 1'b0);
        beat(4'b0111, 2);
        beat(4'b1100, 2);
        beat(4'b1111, 2);
        take("t3", 4'b0100, 3, 1'b0);

        // empty frames
        start_frame(0, 1'b0);
        chk("t4_in_ready", in_ready, 1'b0);
        take("t4a", 4'b0000, 1, 1'b0);
        start_frame(0, 1'b1);
        chk("t4b_in_ready", in_ready, 1'b0);
        take("t4b", 4'b1111, 0, 1'b0);

        // invert re-sampled per frame
        start_frame(2, 1'b1);
        beat(4'b1111, 0);
        beat(4'b1111, 0);
        take("t5a", 4'b1111, 0, 1'b0);
        start_frame(2, 1'b0);
        beat(4'b1010, 0);
        beat(4'b1001, 1);
        take("t5b", 4'b0011, 0, 1'b0);

        // mid-frame reset leaves no residue
        start_frame(4, 1'b1);
        beat(4'b0110, 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t6_rst_in_ready", in_ready, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        start_frame(1, 1'b0);
        beat(4'b1010, 0);
        take("t6a", 4'b1010, 0, 1'b0);

        // maximum-length frame with stray start pulses in ACCUM and DONE
        start_frame(15, 1'b0);
        for (int i = 0; i < 15; i++) begin
            start = (i % 4 == 1);
            invert = 1'b1;
            beat(4'b0001, i % 3 == 2 ? 1 : 0);
        end
        start = 1'b0;
        invert = 1'b0;
        take("t6b", 4'b0001, 2, 1'b1);

        // pins on the model's fold itself
        begin
            logic [W-1:0] q[$];
            q = '{4'b0111, 4'b1100, 4'b1111};
            chk("model_fold", fold(q, 1'b0), 4'b0100);
            chk("model_fold_inv", fold(q, 1'b1), 4'b1011);
        end

        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
